// File: rtl/nibble_add_seq.sv
// nibble_add_seq: W=4*NIB-bit add/subtract sequenced LSB-first over one external 4-bit adder slice.
// Optional macro SUB_EN adds the SUB port (A-B via ~B plus carry-in of 1). Revision 1.0.
`default_nettype none

module nibble_add_seq #(
    parameter int NIB = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [4*NIB-1:0] A,
    input  logic [4*NIB-1:0] B,
    input  logic             CIN,
`ifdef SUB_EN
    input  logic             SUB,
`endif
    output logic [3:0]       ADD_A,
    output logic [3:0]       ADD_B,
    output logic             ADD_C0,
    input  logic [3:0]       ADD_F,
    input  logic             ADD_C4,
    output logic             BUSY,
    output logic             DONE,
    output logic [4*NIB-1:0] S,
    output logic             COUT,
    output logic             OVF
);

    localparam int W  = 4 * NIB;
    localparam int KW = $clog2(NIB);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state;
    logic [KW-1:0] k;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  s_reg;
    logic          carry;
    logic          cout_reg;

    logic          accept;
    logic          last_nib;
    logic [W-1:0]  b_in;
    logic          c_in;

    assign accept   = START && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_nib = (k == KW'(NIB - 1));

    always_comb begin
        b_in = B;
        c_in = CIN;
`ifdef SUB_EN
        // Two's-complement subtract: invert B and inject the +1 through the carry.
        if (SUB) begin
            b_in = ~B;
            c_in = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            k        <= '0;
            op_a     <= '0;
            op_b     <= '0;
            s_reg    <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    s_reg[{k, 2'b00} +: 4] <= ADD_F;
                    carry                  <= ADD_C4;
                    if (last_nib) begin
                        cout_reg <= ADD_C4;
                        k        <= '0;
                        state    <= ST_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
                    if (accept) begin
                        op_a  <= A;
                        op_b  <= b_in;
                        carry <= c_in;
                        k     <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign BUSY   = (state == ST_RUN);
    assign DONE   = (state == ST_DONE);
    assign ADD_A  = BUSY ? op_a[{k, 2'b00} +: 4] : 4'd0;
    assign ADD_B  = BUSY ? op_b[{k, 2'b00} +: 4] : 4'd0;
    assign ADD_C0 = BUSY ? carry : 1'b0;
    assign S      = s_reg;
    assign COUT   = cout_reg;
    // op_b is the post-inversion operand, so this covers subtract overflow too.
    assign OVF    = (op_a[W-1] == op_b[W-1]) && (s_reg[W-1] != op_a[W-1]);

endmodule

`default_nettype wire

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: directed self-checking bench for nibble_add_seq with a behavioural 4-bit adder slice.
`default_nettype none

module tb_nibble_add_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CIN;
`ifdef SUB_EN
    logic         SUB;
`endif
    logic [3:0]   ADD_A;
    logic [3:0]   ADD_B;
    logic         ADD_C0;
    logic [3:0]   ADD_F;
    logic         ADD_C4;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] S;
    logic         COUT;
    logic         OVF;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    nibble_add_seq #(.NIB(NIB)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .A      (A),
        .B      (B),
        .CIN    (CIN),
`ifdef SUB_EN
        .SUB    (SUB),
`endif
        .ADD_A  (ADD_A),
        .ADD_B  (ADD_B),
        .ADD_C0 (ADD_C0),
        .ADD_F  (ADD_F),
        .ADD_C4 (ADD_C4),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .S      (S),
        .COUT   (COUT),
        .OVF    (OVF)
    );

    always #5 CLK = ~CLK;

    // External adder slice
    assign {ADD_C4, ADD_F} = {1'b0, ADD_A} + {1'b0, ADD_B} + {4'b0000, ADD_C0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Launch one operation and check every RUN cycle plus the DONE cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] es, input logic ecout,
                          input logic eovf, input string tag);
        logic [W-1:0] bb;
        logic         c;
        logic [4:0]   r;
        A     = a;
        B     = b;
        CIN   = cin;
`ifdef SUB_EN
        SUB   = sub;
`endif
        START = 1'b1;
        step;
        START = 1'b0;
        A     = 16'hDEAD;
        B     = 16'hBEEF;
        bb    = sub ? ~b : b;
        c     = sub ? 1'b1 : cin;
        for (int n = 0; n < NIB; n++) begin
            check($sformatf("%s busy[%0d]", tag, n), BUSY, 1);
            check($sformatf("%s done_low[%0d]", tag, n), DONE, 0);
            check($sformatf("%s add_a[%0d]", tag, n), ADD_A, a[4*n +: 4]);
            check($sformatf("%s add_b[%0d]", tag, n), ADD_B, bb[4*n +: 4]);
            check($sformatf("%s add_c0[%0d]", tag, n), ADD_C0, c);
            r = {1'b0, a[4*n +: 4]} + {1'b0, bb[4*n +: 4]} + {4'b0000, c};
            c = r[4];
            step;
        end
        check({tag, " done"}, DONE, 1);
        check({tag, " busy_low"}, BUSY, 0);
        check({tag, " s"}, S, es);
        check({tag, " cout"}, COUT, ecout);
        check({tag, " ovf"}, OVF, eovf);
        step;
        check({tag, " done_pulse"}, DONE, 0);
        check({tag, " s_hold"}, S, es);
    endtask

    initial begin
        int n;
        RST   = 1'b1;
        START = 1'b0;
        A     = '0;
        B     = '0;
        CIN   = 1'b0;
`ifdef SUB_EN
        SUB   = 1'b0;
`endif
        step;
        step;
        check("rst busy", BUSY, 0);
        check("rst done", DONE, 0);
        check("rst s", S, 0);
        check("rst cout", COUT, 0);
        check("rst ovf", OVF, 0);
        check("rst add_a", ADD_A, 0);
        check("rst add_b", ADD_B, 0);
        check("rst add_c0", ADD_C0, 0);
        RST = 1'b0;
        step;

        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, "add1");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf");
        run_op(16'hA5C3, 16'h1B2E, 1'b1, 1'b0, 16'hC0F2, 1'b0, 1'b0, "add2");
`ifdef SUB_EN
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub1");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub2");
`endif

        // START held high: a new accept only from DONE, one result per NIB+1 cycles.
        A     = 16'h0001;
        B     = 16'h0001;
        CIN   = 1'b0;
`ifdef SUB_EN
        SUB   = 1'b0;
`endif
        START = 1'b1;
        step;
        for (int c = 0; c < 15; c++) begin
            check($sformatf("cont done[%0d]", c), DONE, (c % 5 == 4) ? 1 : 0);
            check($sformatf("cont busy[%0d]", c), BUSY, (c % 5 == 4) ? 0 : 1);
            if (c % 5 == 4) check($sformatf("cont s[%0d]", c), S, 16'h0002);
            step;
        end
        START = 1'b0;
        n = 0;
        while (!DONE && n < 8) begin
            step;
            n++;
        end
        check("cont final done", DONE, 1);
        check("cont final cycles", n, 4);
        step;
        check("cont idle", BUSY, 0);

        // Reset during the third RUN cycle aborts without DONE.
        A     = 16'h1234;
        B     = 16'h1111;
        START = 1'b1;
        step;
        START = 1'b0;
        step;
        step;
        check("abort in run", BUSY, 1);
        RST = 1'b1;
        step;
        RST = 1'b0;
        check("abort busy", BUSY, 0);
        check("abort done", DONE, 0);
        check("abort s", S, 0);
        check("abort cout", COUT, 0);
        check("abort ovf", OVF, 0);
        check("abort add_a", ADD_A, 0);
        check("abort add_b", ADD_B, 0);
        check("abort add_c0", ADD_C0, 0);
        for (int c = 0; c < 6; c++) begin
            step;
            check($sformatf("abort no_done[%0d]", c), DONE, 0);
        end

        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, "cin");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected summary");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
